// File: rtl/apple2_video_scanner_pkg.sv
// Shared constants and types for the Apple II video timing scanner.
// Cycle/line geometry, page base addresses and the latched display mode.
package apple2_video_scanner_pkg;

   localparam int unsigned TICKS_PER_CYCLE  = 14;
   localparam int unsigned LONG_CYCLE_TICKS = 16;
   localparam int unsigned CYCLES_PER_LINE  = 65;

   localparam int unsigned LINES_PER_FRAME_DEF = 262;
   localparam int unsigned V_ACTIVE_LINES_DEF  = 192;
   localparam int unsigned MIXED_START_DEF     = 160;
   localparam int unsigned H_ACTIVE_START_DEF  = 25;

   localparam logic [15:0] TEXT_PAGE1_BASE  = 16'h0400;
   localparam logic [15:0] TEXT_PAGE2_BASE  = 16'h0800;
   localparam logic [15:0] HIRES_PAGE1_BASE = 16'h2000;
   localparam logic [15:0] HIRES_PAGE2_BASE = 16'h4000;

   typedef struct packed {
      logic text;
      logic mixed;
      logic hires;
      logic page2;
   } video_mode_t;

   localparam video_mode_t MODE_RESET = '{text: 1'b1, mixed: 1'b0, hires: 1'b0, page2: 1'b0};

   // Row-group offset: each third of the screen is 40 bytes further into a 128-byte block.
   function automatic logic [15:0] times40(input logic [1:0] x);
      return {14'b0, x} * 16'd40;
   endfunction

endpackage

// File: rtl/apple2_video_scanner_if.sv
// Mode inputs and video timing outputs of the scanner, grouped as one bus.
// The scanner takes the master side; display/CPU logic takes the slave side.
interface apple2_video_scanner_if;

   logic        TEXT_MODE;
   logic        MIXED_MODE;
   logic        HIRES_MODE;
   logic        PAGE2;
   logic        PHI0;
   logic        CPU_CE;
   logic        VIDEO_LATCH;
   logic [15:0] VIDEO_ADDR;
   logic        HBL;
   logic        VBL;
   logic        COLOR_LINE;

   modport master (
      input  TEXT_MODE, MIXED_MODE, HIRES_MODE, PAGE2,
      output PHI0, CPU_CE, VIDEO_LATCH, VIDEO_ADDR, HBL, VBL, COLOR_LINE
   );

   modport slave (
      output TEXT_MODE, MIXED_MODE, HIRES_MODE, PAGE2,
      input  PHI0, CPU_CE, VIDEO_LATCH, VIDEO_ADDR, HBL, VBL, COLOR_LINE
   );

endinterface

// File: rtl/apple2_video_scanner_addr_gen.sv
// Combinational video RAM address decode from display mode, scanline and column.
// Also reports whether the line is displayed as text.
module apple2_video_scanner_addr_gen
   import apple2_video_scanner_pkg::*;
#(
   parameter int unsigned MIXED_START    = MIXED_START_DEF,
   parameter int unsigned V_ACTIVE_LINES = V_ACTIVE_LINES_DEF
) (
   input  video_mode_t mode,
   input  logic [8:0]  v,
   input  logic [5:0]  col,
   output logic [15:0] addr,
   output logic        text_line
);

   localparam logic [8:0] MIXED_V  = 9'(MIXED_START);
   localparam logic [8:0] ACTIVE_V = 9'(V_ACTIVE_LINES);

   logic [4:0]  r;
   logic [15:0] base;

   assign r = v[7:3];

   always_comb begin
      text_line = mode.text | (mode.mixed & (v >= MIXED_V) & (v < ACTIVE_V));
      if (mode.hires) begin
         base = mode.page2 ? HIRES_PAGE2_BASE : HIRES_PAGE1_BASE;
         addr = base + {3'b0, v[2:0], 10'b0} + {6'b0, v[5:3], 7'b0} + times40(v[7:6])
              + {10'b0, col};
      end else begin
         base = mode.page2 ? TEXT_PAGE2_BASE : TEXT_PAGE1_BASE;
         addr = base + {6'b0, r[2:0], 7'b0} + times40(r[4:3]) + {10'b0, col};
      end
   end

endmodule

// File: rtl/apple2_video_scanner.sv
// Master video timing sequencer and RAM-slot arbiter for the 14.31818 MHz domain.
// Outputs are registered from next-state counters so they line up with the counter state.
module apple2_video_scanner
   import apple2_video_scanner_pkg::*;
#(
   parameter int unsigned LINES_PER_FRAME = LINES_PER_FRAME_DEF,
   parameter int unsigned V_ACTIVE_LINES  = V_ACTIVE_LINES_DEF,
   parameter int unsigned MIXED_START     = MIXED_START_DEF,
   parameter int unsigned H_ACTIVE_START  = H_ACTIVE_START_DEF
) (
   input  logic                   CLK_14M,
   input  logic                   RESET,
   apple2_video_scanner_if.master bus
);

   localparam logic [3:0] SUB_LAST      = 4'(TICKS_PER_CYCLE - 1);
   localparam logic [3:0] SUB_LAST_LONG = 4'(LONG_CYCLE_TICKS - 1);
   localparam logic [3:0] PHI0_RISE     = 4'(TICKS_PER_CYCLE / 2);
   localparam logic [3:0] LATCH_SUB     = 4'(TICKS_PER_CYCLE / 2 - 1);
   localparam logic [6:0] H_LAST        = 7'(CYCLES_PER_LINE - 1);
   localparam logic [6:0] H_ACTIVE      = 7'(H_ACTIVE_START);
   localparam logic [8:0] V_LAST        = 9'(LINES_PER_FRAME - 1);
   localparam logic [8:0] V_ACTIVE      = 9'(V_ACTIVE_LINES);

   logic [3:0]  sub_q, sub_d;
   logic [6:0]  h_q, h_d;
   logic [8:0]  v_q, v_d;
   video_mode_t mode_q, mode_d;
   logic [5:0]  col_d;
   logic [15:0] addr_d;
   logic        text_line_d;

   logic        phi0_q, cpu_ce_q, latch_q, hbl_q, vbl_q, color_q;
   logic [15:0] addr_q;

   always_comb begin
      sub_d = sub_q + 4'd1;
      h_d   = h_q;
      v_d   = v_q;
      if (sub_q == ((h_q == 7'd0) ? SUB_LAST_LONG : SUB_LAST)) begin
         sub_d = 4'd0;
         if (h_q == H_LAST) begin
            h_d = 7'd0;
            v_d = (v_q == V_LAST) ? 9'd0 : v_q + 9'd1;
         end else begin
            h_d = h_q + 7'd1;
         end
      end

      // Sampled on the tick that enters a line, so a frame wrap sees the new line's mode.
      mode_d = mode_q;
      if (h_d == 7'd0 && sub_d == 4'd0) begin
         mode_d = '{text:  bus.TEXT_MODE, mixed: bus.MIXED_MODE,
                    hires: bus.HIRES_MODE, page2: bus.PAGE2};
      end

      col_d = (h_d >= H_ACTIVE) ? 6'(h_d - H_ACTIVE) : 6'd0;
   end

   apple2_video_scanner_addr_gen #(
      .MIXED_START    (MIXED_START),
      .V_ACTIVE_LINES (V_ACTIVE_LINES)
   ) u_addr_gen (
      .mode      (mode_d),
      .v         (v_d),
      .col       (col_d),
      .addr      (addr_d),
      .text_line (text_line_d)
   );

   always_ff @(posedge CLK_14M) begin
      if (RESET) begin
         sub_q    <= 4'd0;
         h_q      <= 7'd0;
         v_q      <= 9'd0;
         mode_q   <= MODE_RESET;
         phi0_q   <= 1'b0;
         cpu_ce_q <= 1'b0;
         latch_q  <= 1'b0;
         addr_q   <= 16'h0000;
         hbl_q    <= 1'b1;
         vbl_q    <= 1'b0;
         color_q  <= 1'b1;
      end else begin
         sub_q    <= sub_d;
         h_q      <= h_d;
         v_q      <= v_d;
         mode_q   <= mode_d;
         phi0_q   <= (sub_d >= PHI0_RISE);
         cpu_ce_q <= (sub_d == ((h_d == 7'd0) ? SUB_LAST_LONG : SUB_LAST));
         latch_q  <= (sub_d == LATCH_SUB) && (h_d >= H_ACTIVE) && (v_d < V_ACTIVE);
         hbl_q    <= (h_d < H_ACTIVE);
         vbl_q    <= (v_d >= V_ACTIVE);
         color_q  <= text_line_d | (v_d >= V_ACTIVE);
         if (sub_d == 4'd0) begin
            addr_q <= addr_d;
         end
      end
   end

   assign bus.PHI0        = phi0_q;
   assign bus.CPU_CE      = cpu_ce_q;
   assign bus.VIDEO_LATCH = latch_q;
   assign bus.VIDEO_ADDR  = addr_q;
   assign bus.HBL         = hbl_q;
   assign bus.VBL         = vbl_q;
   assign bus.COLOR_LINE  = color_q;

endmodule

// File: tb/tb_apple2_video_scanner.sv
// Self-checking bench for apple2_video_scanner, built with a shortened frame
// (66 lines, VBL from line 48, mixed text from line 40) to keep the run short.
module tb_apple2_video_scanner;

   localparam int LINE = 912;

   logic CLK_14M;
   logic RESET;

   apple2_video_scanner_if bus ();

   apple2_video_scanner #(
      .LINES_PER_FRAME (66),
      .V_ACTIVE_LINES  (48),
      .MIXED_START     (40),
      .H_ACTIVE_START  (25)
   ) dut (
      .CLK_14M (CLK_14M),
      .RESET   (RESET),
      .bus     (bus)
   );

   initial CLK_14M = 1'b0;
   always #5 CLK_14M = ~CLK_14M;

   typedef struct {
      int          v;
      int          col;
      logic        text;
      logic        mixed;
      logic        hires;
      logic        page2;
      logic [15:0] addr;
      logic        color;
      logic        vbl;
   } vec_t;

   vec_t vecs[12];

   int   t;
   int   n_pass;
   int   n_total;
   int   ce_line0, phi0_h0;
   int   hbl_rise1, hbl_rise2, vbl_rise, vbl_fall;
   logic hbl_prev, vbl_prev;
   int   latch_cnt[80];

   function automatic int pos(input int v, input int h, input int sub);
      return v * LINE + ((h == 0) ? sub : 14 * h + 2 + sub);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
   endtask

   task automatic clear_track();
      t         = 0;
      ce_line0  = 0;
      phi0_h0   = 0;
      hbl_rise1 = -1;
      hbl_rise2 = -1;
      vbl_rise  = -1;
      vbl_fall  = -1;
      hbl_prev  = 1'b1;
      vbl_prev  = 1'b0;
      for (int i = 0; i < 80; i++) latch_cnt[i] = 0;
   endtask

   task automatic step();
      @(posedge CLK_14M);
      #1;
      t++;
      if (bus.CPU_CE && t <= LINE) ce_line0++;
      if (bus.PHI0 && t <= 15) phi0_h0++;
      if (bus.HBL && !hbl_prev) begin
         if (hbl_rise1 < 0) hbl_rise1 = t;
         else if (hbl_rise2 < 0) hbl_rise2 = t;
      end
      if (bus.VBL && !vbl_prev && vbl_rise < 0) vbl_rise = t;
      if (!bus.VBL && vbl_prev && vbl_fall < 0) vbl_fall = t;
      if (bus.VIDEO_LATCH && (t / LINE) < 80) latch_cnt[t / LINE]++;
      hbl_prev = bus.HBL;
      vbl_prev = bus.VBL;
   endtask

   task automatic goto(input int target);
      while (t < target) step();
   endtask

   task automatic set_mode(input logic text, input logic mixed, input logic hires,
                           input logic page2);
      bus.TEXT_MODE  = text;
      bus.MIXED_MODE = mixed;
      bus.HIRES_MODE = hires;
      bus.PAGE2      = page2;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_phi0"},  32'(bus.PHI0),        32'd0);
      check({tag, "_cpuce"}, 32'(bus.CPU_CE),      32'd0);
      check({tag, "_latch"}, 32'(bus.VIDEO_LATCH), 32'd0);
      check({tag, "_addr"},  32'(bus.VIDEO_ADDR),  32'h0000);
      check({tag, "_hbl"},   32'(bus.HBL),         32'd1);
      check({tag, "_vbl"},   32'(bus.VBL),         32'd0);
      check({tag, "_color"}, 32'(bus.COLOR_LINE),  32'd1);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;

      //          v   col txt mix hir pg2  addr      color vbl
      vecs[0]  = '{3,  5,  1,  0,  0,  0, 16'h0405, 1'b1, 1'b0};
      vecs[1]  = '{8,  0,  1,  0,  0,  0, 16'h0480, 1'b1, 1'b0};
      vecs[2]  = '{9,  0,  0,  0,  1,  0, 16'h2480, 1'b0, 1'b0};
      vecs[3]  = '{10, 39, 0,  0,  0,  1, 16'h08A7, 1'b0, 1'b0};
      vecs[4]  = '{17, 39, 0,  0,  1,  1, 16'h4527, 1'b0, 1'b0};
      vecs[5]  = '{20, 0,  1,  0,  0,  1, 16'h0900, 1'b1, 1'b0};
      vecs[6]  = '{39, 10, 0,  1,  1,  0, 16'h3E0A, 1'b0, 1'b0};
      vecs[7]  = '{40, 0,  0,  1,  1,  0, 16'h2280, 1'b1, 1'b0};
      vecs[8]  = '{47, 39, 0,  1,  1,  0, 16'h3EA7, 1'b1, 1'b0};
      vecs[9]  = '{48, 0,  0,  0,  1,  0, 16'h2300, 1'b1, 1'b1};
      vecs[10] = '{64, 0,  1,  0,  0,  0, 16'h0428, 1'b1, 1'b1};
      vecs[11] = '{65, 0,  0,  0,  1,  0, 16'h2428, 1'b1, 1'b1};

      // Power-up reset with hi-res page 2 requested: the latch must still come up text page 1.
      RESET = 1'b1;
      set_mode(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (3) @(posedge CLK_14M);
      #1;
      check_reset_vals("rst");
      RESET = 1'b0;
      clear_track();

      step();
      check("t1_phi0", 32'(bus.PHI0), 32'd0);
      check("t1_hbl",  32'(bus.HBL), 32'd1);
      check("t1_vbl",  32'(bus.VBL), 32'd0);
      check("t1_addr", 32'(bus.VIDEO_ADDR), 32'h0000);
      goto(13);  check("ce_sub13_long",  32'(bus.CPU_CE), 32'd0);
      goto(15);  check("ce_sub15_long",  32'(bus.CPU_CE), 32'd1);
      goto(29);  check("ce_h1_sub13",    32'(bus.CPU_CE), 32'd1);
      goto(351); check("hbl_h24",        32'(bus.HBL), 32'd1);
      goto(352); check("hbl_h25",        32'(bus.HBL), 32'd0);
      goto(355); check("addr_v0_col0",   32'(bus.VIDEO_ADDR), 32'h0400);
      goto(357); check("latch_sub5",     32'(bus.VIDEO_LATCH), 32'd0);
      goto(358); check("latch_sub6",     32'(bus.VIDEO_LATCH), 32'd1);
      goto(565);
      check("addr_v0_col15", 32'(bus.VIDEO_ADDR), 32'h040F);
      check("hbl_h40",       32'(bus.HBL), 32'd0);

      // Mid-line reset at h=40.
      RESET = 1'b1;
      @(posedge CLK_14M);
      #1;
      check_reset_vals("midrst");
      RESET = 1'b0;
      set_mode(1'b1, 1'b0, 1'b0, 1'b0);
      clear_track();

      goto(2 * LINE);
      check("ce_per_line",     32'(ce_line0), 32'd65);
      check("phi0_hi_long",    32'(phi0_h0), 32'd9);
      check("hbl_first_rise",  32'(hbl_rise1), 32'd912);
      check("hbl_period",      32'(hbl_rise2 - hbl_rise1), 32'd912);

      for (int i = 0; i < 12; i++) begin
         set_mode(vecs[i].text, vecs[i].mixed, vecs[i].hires, vecs[i].page2);
         goto(pos(vecs[i].v, 25 + vecs[i].col, 3));
         check($sformatf("vec%0d_addr", i),  32'(bus.VIDEO_ADDR), 32'(vecs[i].addr));
         check($sformatf("vec%0d_color", i), 32'(bus.COLOR_LINE), 32'(vecs[i].color));
         check($sformatf("vec%0d_vbl", i),   32'(bus.VBL), 32'(vecs[i].vbl));
         check($sformatf("vec%0d_hbl", i),   32'(bus.HBL), 32'd0);
      end

      // Frame wrap: page 2 requested during the last line applies to line 0 of the next frame.
      set_mode(1'b1, 1'b0, 1'b0, 1'b1);
      goto(pos(66, 25, 3));
      check("wrap_addr",  32'(bus.VIDEO_ADDR), 32'h0800);
      check("wrap_color", 32'(bus.COLOR_LINE), 32'd1);
      check("wrap_vbl",   32'(bus.VBL), 32'd0);
      check("vbl_rise",   32'(vbl_rise), 32'(48 * LINE));
      check("vbl_fall",   32'(vbl_fall), 32'(66 * LINE));

      check("latch_line0",  32'(latch_cnt[0]),  32'd40);
      check("latch_line5",  32'(latch_cnt[5]),  32'd40);
      check("latch_line47", 32'(latch_cnt[47]), 32'd40);
      check("latch_line48", 32'(latch_cnt[48]), 32'd0);
      check("latch_line60", 32'(latch_cnt[60]), 32'd0);

      // Dropping TEXT_MODE at h=30 must not recolour the current line.
      goto(pos(66, 30, 0));
      set_mode(1'b0, 1'b0, 1'b0, 1'b1);
      goto(pos(66, 64, 13));
      check("toggle_same_line", 32'(bus.COLOR_LINE), 32'd1);
      step();
      check("toggle_next_line", 32'(bus.COLOR_LINE), 32'd0);
      check("toggle_next_addr", 32'(bus.VIDEO_ADDR), 32'h0800);
      check("toggle_next_hbl",  32'(bus.HBL), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
